// File: rtl/sal_ref_ctrl_pkg.sv
// Shared DDR2 refresh parameters: default widths, debt limit and refresh FSM states.
package sal_ref_ctrl_pkg;

  localparam int unsigned DEF_TREFI_W  = 16;
  localparam int unsigned DEF_TRFC_W   = 8;
  localparam int unsigned DEF_MAX_DEBT = 8;
  localparam int unsigned DEF_DEBT_W   = $clog2(DEF_MAX_DEBT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RFC  = 2'd2
  } ref_state_t;

endpackage

// File: rtl/sal_ref_timer.sv
// tREFI interval down-counter; tick_c_o pulses combinationally on each interval expiry.
module sal_ref_timer
  import sal_ref_ctrl_pkg::*;
#(
  parameter int unsigned TREFI_W = DEF_TREFI_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [TREFI_W-1:0] trefi_i,
  output logic               tick_c_o
);

  logic [TREFI_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic               pend_q, pend_d;
  logic               run;

  // A pending load counts the load cycle itself as the first cycle of the interval.
  always_comb begin
    run      = en_i && (trefi_i != '0);
    cnt_eff  = pend_q ? (trefi_i - TREFI_W'(1)) : cnt_q;
    tick_c_o = run && (cnt_eff == '0);
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    if (!run) begin
      cnt_d  = trefi_i - TREFI_W'(1);
      pend_d = 1'b1;
    end else if (tick_c_o) begin
      cnt_d  = trefi_i - TREFI_W'(1);
      pend_d = 1'b0;
    end else begin
      cnt_d  = cnt_eff - TREFI_W'(1);
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/sal_ref_ctrl.sv
// DDR2 refresh scheduler: tracks refresh debt and handshakes REF with the bank controller.
// Optional SAL_REF_URGENT_EN adds ref_urgent_o (debt at or above MAX_DEBT-1).
module sal_ref_ctrl
  import sal_ref_ctrl_pkg::*;
#(
  parameter int unsigned TREFI_W  = DEF_TREFI_W,
  parameter int unsigned TRFC_W   = DEF_TRFC_W,
  parameter int unsigned MAX_DEBT = DEF_MAX_DEBT,
  parameter int unsigned DEBT_W   = DEF_DEBT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ref_en_i,
  input  logic [TREFI_W-1:0] trefi_i,
  input  logic [TRFC_W-1:0]  trfc_i,
  output logic               ref_req_o,
  input  logic               ref_gnt_i,
  output logic               ref_busy_o,
  output logic [DEBT_W-1:0]  debt_o,
  output logic               ref_overflow_o
`ifdef SAL_REF_URGENT_EN
  ,
  output logic               ref_urgent_o
`endif
);

  localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0] DEBT_URG = DEBT_W'(MAX_DEBT - 1);

  ref_state_t          state_q, state_d;
  logic [DEBT_W-1:0]   debt_q, debt_d;
  logic [TRFC_W-1:0]   rfc_q, rfc_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;
  logic                urg_q, urg_d;
  logic                tick;
  logic                gnt;

  sal_ref_timer #(
    .TREFI_W (TREFI_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (ref_en_i),
    .trefi_i  (trefi_i),
    .tick_c_o (tick)
  );

  // Debt bookkeeping; a grant only counts while a request is outstanding.
  always_comb begin
    gnt    = (state_q == REQ) && ref_gnt_i;
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (tick && !gnt) begin
      if (debt_q == DEBT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        debt_d = debt_q + DEBT_W'(1);
      end
    end else if (gnt && !tick) begin
      debt_d = debt_q - DEBT_W'(1);
    end
    urg_d = (debt_d >= DEBT_URG);
  end

  // Request/grant/tRFC sequencing; outputs registered from the next state.
  always_comb begin
    state_d = state_q;
    rfc_d   = rfc_q;
    case (state_q)
      IDLE: begin
        if (debt_q != '0) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (ref_gnt_i) begin
          state_d = RFC;
          rfc_d   = (trfc_i == '0) ? '0 : (trfc_i - TRFC_W'(1));
        end
      end
      RFC: begin
        if (rfc_q == '0) begin
          state_d = IDLE;
        end else begin
          rfc_d = rfc_q - TRFC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == REQ);
    busy_d = (state_d == RFC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      debt_q  <= '0;
      rfc_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      urg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      debt_q  <= debt_d;
      rfc_q   <= rfc_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      urg_q   <= urg_d;
    end
  end

  assign ref_req_o      = req_q;
  assign ref_busy_o     = busy_q;
  assign debt_o         = debt_q;
  assign ref_overflow_o = ovf_q;
`ifdef SAL_REF_URGENT_EN
  assign ref_urgent_o   = urg_q;
`else
  logic unused_urg;
  assign unused_urg = urg_q;
`endif

endmodule
